// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port DataMemory arbiter.
// The sequencer FSM states, port identifiers and word-alignment helper live here.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both request/response ports plus the DataMemory side of the arbiter.
// The arbiter uses the slave modport; masters and the memory model sit on the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_address, mem_read, mem_write, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_address, mem_read, mem_write, mem_write_data,
        input  mem_read_data
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant plus the last-grant flop.
// On a tie the port that did not win last time is chosen; port 0 wins the first tie after reset.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    input  logic       update_id,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT1;
        end else if (update_en) begin
            last_grant <= update_id;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[1]) begin
            gnt_id = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer serialising two masters onto the single-ported DataMemory.
// One transaction at a time: IDLE -> ACCESS -> (WAIT) -> RESP, with misaligned requests short-cut to RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    state_t            state;
    state_t            state_nx;
    logic              port_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              gnt_valid;
    logic              gnt_id;
    logic              accept;
    logic              capture;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       ({bus.req1_valid, bus.req0_valid}),
        .update_en (state == RESP),
        .update_id (port_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign win_we    = (gnt_id == PORT1) ? bus.req1_we    : bus.req0_we;
    assign win_addr  = (gnt_id == PORT1) ? bus.req1_addr  : bus.req0_addr;
    assign win_wdata = (gnt_id == PORT1) ? bus.req1_wdata : bus.req0_wdata;
    assign accept    = (state == IDLE) && gnt_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            port_q  <= PORT0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                port_q  <= gnt_id;
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                err_q   <= ~is_aligned(win_addr[1:0]);
                rdata_q <= '0;
            end
            if (state == ACCESS) begin
                cnt_q <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                rdata_q <= bus.mem_read_data;
            end
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nx           = state;
        capture            = 1'b0;
        bus.req0_ready     = 1'b0;
        bus.req1_ready     = 1'b0;
        bus.rsp0_valid     = 1'b0;
        bus.rsp0_rdata     = '0;
        bus.rsp0_err       = 1'b0;
        bus.rsp1_valid     = 1'b0;
        bus.rsp1_rdata     = '0;
        bus.rsp1_err       = 1'b0;
        bus.mem_address    = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_write_data = '0;
        case (state)
            IDLE: begin
                if (gnt_valid && !reset) begin
                    bus.req0_ready = (gnt_id == PORT0);
                    bus.req1_ready = (gnt_id == PORT1);
                    state_nx = is_aligned(win_addr[1:0]) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                bus.mem_address = addr_q;
                if (we_q) begin
                    bus.mem_write      = 1'b1;
                    bus.mem_write_data = wdata_q;
                    state_nx           = RESP;
                end else begin
                    bus.mem_read = 1'b1;
                    if (RD_LATENCY > 0) begin
                        state_nx = WAIT;
                    end else begin
                        capture  = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            WAIT: begin
                bus.mem_address = addr_q;
                bus.mem_read    = 1'b1;
                if (cnt_q == '0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (port_q == PORT1) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_rdata = rdata_q;
                    bus.rsp1_err   = err_q;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_rdata = rdata_q;
                    bus.rsp0_err   = err_q;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one DUT with combinational reads, one with RD_LATENCY=2.
// Each scenario task pushes expected responses and compares them as the selected DUT responds.
module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if bus0 ();
    dmem_arbiter_if bus2 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    logic        sel;
    logic [1:0]  v;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;

    assign bus0.req0_valid = v[0] & ~sel;
    assign bus0.req1_valid = v[1] & ~sel;
    assign bus0.req0_we    = we[0];
    assign bus0.req1_we    = we[1];
    assign bus0.req0_addr  = a0;
    assign bus0.req1_addr  = a1;
    assign bus0.req0_wdata = d0;
    assign bus0.req1_wdata = d1;
    assign bus2.req0_valid = v[0] & sel;
    assign bus2.req1_valid = v[1] & sel;
    assign bus2.req0_we    = we[0];
    assign bus2.req1_we    = we[1];
    assign bus2.req0_addr  = a0;
    assign bus2.req1_addr  = a1;
    assign bus2.req0_wdata = d0;
    assign bus2.req1_wdata = d1;

    // Memory models: combinational read for dut0, two-stage registered read for dut2.
    logic [31:0] mem0 [0:63];
    logic [31:0] mem2 [0:63];
    logic [31:0] q1 = 32'hBAD0_BAD0;
    logic [31:0] q2 = 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (bus0.mem_write) mem0[bus0.mem_address[7:2]] <= bus0.mem_write_data;
        if (bus2.mem_write) mem2[bus2.mem_address[7:2]] <= bus2.mem_write_data;
        q1 <= bus2.mem_read ? mem2[bus2.mem_address[7:2]] : 32'hBAD0_BAD0;
        q2 <= q1;
    end
    assign bus0.mem_read_data = mem0[bus0.mem_address[7:2]];
    assign bus2.mem_read_data = q2;

    logic        o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1, o_rd, o_wr;
    logic [31:0] o_rdata0, o_rdata1, o_addr, o_wdata;
    assign o_rdy0   = sel ? bus2.req0_ready     : bus0.req0_ready;
    assign o_rdy1   = sel ? bus2.req1_ready     : bus0.req1_ready;
    assign o_rv0    = sel ? bus2.rsp0_valid     : bus0.rsp0_valid;
    assign o_rv1    = sel ? bus2.rsp1_valid     : bus0.rsp1_valid;
    assign o_err0   = sel ? bus2.rsp0_err       : bus0.rsp0_err;
    assign o_err1   = sel ? bus2.rsp1_err       : bus0.rsp1_err;
    assign o_rdata0 = sel ? bus2.rsp0_rdata     : bus0.rsp0_rdata;
    assign o_rdata1 = sel ? bus2.rsp1_rdata     : bus0.rsp1_rdata;
    assign o_rd     = sel ? bus2.mem_read       : bus0.mem_read;
    assign o_wr     = sel ? bus2.mem_write      : bus0.mem_write;
    assign o_addr   = sel ? bus2.mem_address    : bus0.mem_address;
    assign o_wdata  = sel ? bus2.mem_write_data : bus0.mem_write_data;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    function automatic exp_t mk(input int port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        return e;
    endfunction

    task automatic issue(input int port, input logic w, input logic [31:0] ad,
                         input logic [31:0] wd, output bit ok);
        @(negedge clk);
        if (port == 0) begin we[0] = w; a0 = ad; d0 = wd; v[0] = 1'b1; end
        else           begin we[1] = w; a1 = ad; d1 = wd; v[1] = 1'b1; end
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((port == 0) ? o_rdy0 : o_rdy1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (ok) begin @(posedge clk); #1; end
        v[port] = 1'b0;
    endtask

    task automatic get_rsp(input int budget, output int port, output logic [31:0] rd,
                           output logic er, output int lat, output int nrd, output int nwr,
                           output int nboth, output logic [31:0] maddr, output logic [31:0] mwdata);
        port = -1; rd = '0; er = 1'b0; lat = 0; nrd = 0; nwr = 0; nboth = 0;
        maddr = '0; mwdata = '0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            nrd += int'(o_rd);
            nwr += int'(o_wr);
            if (o_rd && o_wr) nboth++;
            if (o_rd || o_wr) begin maddr = o_addr; mwdata = o_wdata; end
            if (o_rv0 || o_rv1) begin
                if (o_rv0 && o_rv1) nboth++;
                lat  = i;
                port = o_rv1 ? 1 : 0;
                rd   = o_rv1 ? o_rdata1 : o_rdata0;
                er   = o_rv1 ? o_err1 : o_err0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v = 2'b11; we = 2'b00; a0 = 32'h0; a1 = 32'h4; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = s[0];
            #1;
            tests_run++;
            if ({o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1, o_rd, o_wr} !== 8'h00) begin
                tests_failed++;
                $display("[TB] FAIL reset_ctrl dut%0d: got %b, expected 00000000", s * 2,
                         {o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1, o_rd, o_wr});
            end
            tests_run++;
            if ({o_addr, o_wdata, o_rdata0, o_rdata1} !== 128'h0) begin
                tests_failed++;
                $display("[TB] FAIL reset_data dut%0d: got addr=%h wd=%h rd0=%h rd1=%h, expected 0",
                         s * 2, o_addr, o_wdata, o_rdata0, o_rdata1);
            end
        end
        v = 2'b00;
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_tie();
        int p, lat, nrd, nwr, nb;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        @(negedge clk);
        we = 2'b11; a0 = 32'h40; d0 = 32'hA5A5_0001; a1 = 32'h44; d1 = 32'h5A5A_0002;
        v = 2'b11;
        #1;
        tests_run++;
        if ({o_rdy1, o_rdy0} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL tie_first_grant: got ready=%b, expected 01", {o_rdy1, o_rdy0});
        end
        sb.push_back(mk(0, 32'h0, 1'b0));
        @(posedge clk); #1;
        v[0] = 1'b0;
        get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (p !== e.port || rd !== e.rdata || er !== e.err || lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL tie_rsp_a: got port=%0d rd=%h err=%b lat=%0d, expected port=%0d rd=%h err=%b lat=2",
                     p, rd, er, lat, e.port, e.rdata, e.err);
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (o_rdy0 || o_rdy1) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok || {o_rdy1, o_rdy0} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL tie_second_grant: got ready=%b seen=%0d, expected 10", {o_rdy1, o_rdy0}, ok);
        end
        sb.push_back(mk(1, 32'h0, 1'b0));
        @(posedge clk); #1;
        v[1] = 1'b0;
        get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (p !== e.port || rd !== e.rdata || er !== e.err || lat !== 2 || ma !== 32'h44 || mw !== 32'h5A5A_0002) begin
            tests_failed++;
            $display("[TB] FAIL tie_rsp_b: got port=%0d rd=%h err=%b lat=%0d addr=%h wd=%h, expected port=%0d rd=%h err=%b lat=2 addr=44 wd=5a5a0002",
                     p, rd, er, lat, ma, mw, e.port, e.rdata, e.err);
        end
    endtask

    task automatic test_store_load();
        int p, lat, nrd, nwr, nb;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        sb.push_back(mk(0, 32'h0, 1'b0));
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, ok);
        get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || rd !== e.rdata || er !== e.err || lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL store_rsp: got hs=%0d port=%0d rd=%h err=%b lat=%0d, expected hs=1 port=%0d rd=%h err=%b lat=2",
                     ok, p, rd, er, lat, e.port, e.rdata, e.err);
        end
        tests_run++;
        if (nwr !== 1 || nrd !== 0 || nb !== 0 || ma !== 32'h10 || mw !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL store_mem: got wr=%0d rd=%0d both=%0d addr=%h wd=%h, expected wr=1 rd=0 both=0 addr=10 wd=deadbeef",
                     nwr, nrd, nb, ma, mw);
        end
        sb.push_back(mk(0, 32'hDEAD_BEEF, 1'b0));
        issue(0, 1'b0, 32'h10, 32'h0, ok);
        get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || rd !== e.rdata || er !== e.err || lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL load_rsp: got hs=%0d port=%0d rd=%h err=%b lat=%0d, expected hs=1 port=%0d rd=%h err=%b lat=2",
                     ok, p, rd, er, lat, e.port, e.rdata, e.err);
        end
        tests_run++;
        if (nrd !== 1 || nwr !== 0 || ma !== 32'h10) begin
            tests_failed++;
            $display("[TB] FAIL load_mem: got rd=%0d wr=%0d addr=%h, expected rd=1 wr=0 addr=10", nrd, nwr, ma);
        end
    endtask

    task automatic test_misaligned();
        int p, lat, nrd, nwr, nb;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        sb.push_back(mk(1, 32'h0, 1'b1));
        issue(1, 1'b0, 32'h13, 32'h0, ok);
        get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || rd !== e.rdata || er !== e.err || lat !== 1) begin
            tests_failed++;
            $display("[TB] FAIL misaligned_rsp: got hs=%0d port=%0d rd=%h err=%b lat=%0d, expected hs=1 port=%0d rd=%h err=%b lat=1",
                     ok, p, rd, er, lat, e.port, e.rdata, e.err);
        end
        tests_run++;
        if (nrd !== 0 || nwr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL misaligned_mem: got rd=%0d wr=%0d, expected 0 0", nrd, nwr);
        end
    endtask

    task automatic test_back_to_back();
        int p, lat, nrd, nwr, nb, g;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        @(negedge clk);
        we = 2'b00; a0 = 32'h40; a1 = 32'h44;
        v = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (o_rdy0 || o_rdy1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            g = o_rdy1 ? 1 : 0;
            tests_run++;
            if (!ok || (o_rdy0 && o_rdy1) || g !== (k % 2)) begin
                tests_failed++;
                $display("[TB] FAIL alt_grant[%0d]: got ready=%b, expected port %0d", k, {o_rdy1, o_rdy0}, k % 2);
            end
            sb.push_back(mk(k % 2, (k % 2 == 1) ? 32'h5A5A_0002 : 32'hA5A5_0001, 1'b0));
            @(posedge clk);
            get_rsp(8, p, rd, er, lat, nrd, nwr, nb, ma, mw);
            e = sb.pop_front();
            tests_run++;
            if (p !== e.port || rd !== e.rdata || er !== e.err || nb !== 0) begin
                tests_failed++;
                $display("[TB] FAIL alt_rsp[%0d]: got port=%0d rd=%h err=%b both=%0d, expected port=%0d rd=%h err=%b both=0",
                         k, p, rd, er, nb, e.port, e.rdata, e.err);
            end
            @(negedge clk);
        end
        v = 2'b00;
    endtask

    task automatic test_latency();
        int p, lat, nrd, nwr, nb;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        sel = 1'b1;
        sb.push_back(mk(1, 32'h0, 1'b0));
        issue(1, 1'b1, 32'h20, 32'h1234_5678, ok);
        get_rsp(10, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || rd !== e.rdata || er !== e.err || lat !== 2 || nwr !== 1) begin
            tests_failed++;
            $display("[TB] FAIL lat_store: got hs=%0d port=%0d rd=%h err=%b lat=%0d wr=%0d, expected hs=1 port=1 rd=0 err=0 lat=2 wr=1",
                     ok, p, rd, er, lat, nwr);
        end
        sb.push_back(mk(0, 32'h1234_5678, 1'b0));
        issue(0, 1'b0, 32'h20, 32'h0, ok);
        get_rsp(10, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (!ok || p !== e.port || rd !== e.rdata || er !== e.err || lat !== 4) begin
            tests_failed++;
            $display("[TB] FAIL lat_load_rsp: got hs=%0d port=%0d rd=%h err=%b lat=%0d, expected hs=1 port=%0d rd=%h err=%b lat=4",
                     ok, p, rd, er, lat, e.port, e.rdata, e.err);
        end
        tests_run++;
        if (nrd !== 3 || nwr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL lat_mem_read: got rd=%0d wr=%0d cycles, expected rd=3 wr=0", nrd, nwr);
        end
    endtask

    task automatic test_reset_mid_wait();
        int p, lat, nrd, nwr, nb, stray;
        logic [31:0] rd, ma, mw;
        logic er;
        bit ok;
        exp_t e;
        sel = 1'b1;
        issue(1, 1'b0, 32'h20, 32'h0, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok || o_rd !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wait_mem_read: got hs=%0d mem_read=%b, expected 1 1", ok, o_rd);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({o_rdy0, o_rdy1, o_rv0, o_rv1, o_rd, o_wr} !== 6'b0 || o_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got ctrl=%b addr=%h, expected 000000 0",
                     {o_rdy0, o_rdy1, o_rv0, o_rv1, o_rd, o_wr}, o_addr);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_rv0 || o_rv1) stray++;
            if (i == 2) reset = 1'b0;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("[TB] FAIL dropped_rsp: got %0d response strobes, expected 0", stray);
        end
        we = 2'b00; a0 = 32'h20; a1 = 32'h20;
        v = 2'b11;
        #1;
        tests_run++;
        if ({o_rdy1, o_rdy0} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_tie: got ready=%b, expected 01", {o_rdy1, o_rdy0});
        end
        sb.push_back(mk(0, 32'h1234_5678, 1'b0));
        @(posedge clk); #1;
        v = 2'b00;
        get_rsp(10, p, rd, er, lat, nrd, nwr, nb, ma, mw);
        e = sb.pop_front();
        tests_run++;
        if (p !== e.port || rd !== e.rdata || er !== e.err || lat !== 4) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_load: got port=%0d rd=%h err=%b lat=%0d, expected port=%0d rd=%h err=%b lat=4",
                     p, rd, er, lat, e.port, e.rdata, e.err);
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_tie();
        test_store_load();
        test_misaligned();
        test_back_to_back();
        test_latency();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported `DataMemory` block. It accepts load/store requests from two masters over valid/ready handshakes: port 0 is the CPU load/store unit and port 1 is the debug/DMA loader. It grants them round-robin and drives `DataMemory`'s `address`/`mem_read`/`mem_write`/`write_data` for exactly one transaction at a time. It returns read data or a write acknowledgement on a per-port response strobe.

## Interface
Parameters:
- `ADDR_W`, 32, width of request and memory address.
- `DATA_W`, 32, width of write and read data.
- `RD_LATENCY`, 0, extra cycles after the ACCESS cycle before `mem_read_data` is valid. 0 means a combinational read.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 request present.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_we`  in  1  1 = store, 0 = load.
- `req0_addr`  in  ADDR_W  byte address; must be word-aligned.
- `req0_wdata`  in  DATA_W  store data.
- `rsp0_valid`  out  1  one-cycle response strobe.
- `rsp0_rdata`  out  DATA_W  load data; 0 for stores and errors.
- `rsp0_err`  out  1  misaligned request, no memory access performed.
- `req1_*`, `rsp1_*`  same as port 0, for port 1.
- `mem_address`  out  ADDR_W  to `DataMemory` `address`.
- `mem_read`  out  1  to `DataMemory` `mem_read`.
- `mem_write`  out  1  to `DataMemory` `mem_write`.
- `mem_write_data`  out  DATA_W  to `DataMemory` `write_data`.
- `mem_read_data`  in  DATA_W  from `DataMemory` `read_data`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - If any `reqN_valid` is high, pick a winner, assert its `reqN_ready` combinationally, and register `we`, `addr`, `wdata` and the port id.
  - If the registered address is aligned (`addr[1:0]==0`), go to ACCESS. Otherwise go to RESP with err=1.
- **Arbitration**
  - Only one port valid: that port wins.
  - Both valid: the port not granted last time wins.
  - After reset, `last_grant`=1, so port 0 wins the first tie.
  - `reqN_ready` is never high outside IDLE and never high for both ports at once.
- **ACCESS** (1 cycle)
  - Drive `mem_address` = registered address.
  - Store: `mem_write`=1 and `mem_write_data` = wdata, then go to RESP.
  - Load: `mem_read`=1. Go to WAIT if `RD_LATENCY`>0. Otherwise capture `mem_read_data` at the end of this cycle and go to RESP.
- **WAIT**
  - Hold `mem_read`=1 and the address.
  - A down-counter loaded with `RD_LATENCY`-1 counts the cycles.
  - At zero, capture `mem_read_data` and go to RESP.
- **RESP** (1 cycle)
  - Assert `rspN_valid` for the granted port only, with `rdata`/`err`.
  - Update `last_grant`, then go to IDLE.
- **Protocol**
  - Masters hold `valid` and its payload stable until `ready`.
  - Masters must be able to accept the response; there is no back-pressure.
- **Reset**
  - All outputs go to 0 and the state goes to IDLE immediately, even mid-transaction.
  - An in-flight request is dropped with no response, and `mem_write` falls asynchronously, so no partial write is extended.

## Timing
- Handshake at cycle T.
- Store: `mem_write` high during T+1, `rsp_valid` during T+2.
- Load: `rsp_valid` during T+2+`RD_LATENCY`.
- Misaligned request: `rsp_valid`+`err` during T+1, and no `mem_read`/`mem_write` pulse.
- Next handshake earliest in the cycle after RESP, so back-to-back stores take 3 cycles each.
- `mem_read` and `mem_write` are never high together.
- `mem_*` outputs are 0 in IDLE and RESP.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - the port-id constants PORT0/PORT1;
  - the alignment mask constant.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with grant-update enable. It is purely combinational, plus the `last_grant` flop.

## Test plan
- Port 0 stores 0xDEADBEEF at 0x10, then loads 0x10 → `mem_write` for one cycle, then `rsp0_valid` with `rsp0_rdata`=0xDEADBEEF, `rsp0_err`=0.
- Both ports request in the same cycle after reset → port 0 is granted first and port 1 next. Repeat with both held valid → the grants alternate 0,1,0,1.
- Port 1 loads at 0x13 → `rsp1_valid`=1 and `rsp1_err`=1 one cycle after the handshake, `rsp1_rdata`=0, with no `mem_read`.
- `RD_LATENCY`=2, load 0x20 preloaded with 0x12345678 → `rsp_valid` at T+4 with 0x12345678, and `mem_read` high for exactly 3 cycles.
- Assert `reset` during the WAIT of a load → all outputs 0 at once, no `rsp_valid`. A request after reset is served normally, and port 0 wins the first tie.
